// File: rtl/seq_adder_pkg.sv
// Shared types and default sizing for the sequential slice adder.
package seq_adder_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CHUNK = 8;

  typedef enum logic [1:0] {IDLE, CALC, DONE} seq_adder_state_e;

endpackage

// File: rtl/seq_adder_slice.sv
// Combinational CHUNK-bit adder slice with carry in/out.
module adder_slice #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  localparam int unsigned SW = CHUNK + 1;

  assign {co, s} = SW'(a) + SW'(b) + SW'(ci);

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle add/subtract, one CHUNK-bit slice per clock, LSB first.
// Define SEQ_ADDER_FLAGS_EN to compute the ovf and zero flags (tied to 0 otherwise).
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);
  localparam logic [CHUNK-1:0] SLICE_MASK = '1;

  if ((CHUNK == 0) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("seq_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  seq_adder_state_e state_q, state_nxt;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             accept, step, last;
  logic [31:0]      offs;
  logic [CHUNK-1:0] a_slice, b_slice, s_slice;
  logic             co_slice;
  logic [WIDTH-1:0] sum_nxt;

  // Next-state and datapath enables
  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    step      = 1'b0;
    last      = (idx_q == LAST_IDX);
    unique case (state_q)
      IDLE: if (in_valid) begin
        accept    = 1'b1;
        state_nxt = CALC;
      end
      CALC: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  // Select slice k of the operands and splice the slice result into the sum
  always_comb begin
    offs    = 32'(idx_q) * 32'(CHUNK);
    a_slice = CHUNK'(a_q >> offs);
    b_slice = CHUNK'(b_q >> offs);
    sum_nxt = (sum & ~(WIDTH'(SLICE_MASK) << offs)) | (WIDTH'(s_slice) << offs);
  end

  adder_slice #(.CHUNK(CHUNK)) u_slice (
    .a  (a_slice),
    .b  (b_slice),
    .ci (carry_q),
    .s  (s_slice),
    .co (co_slice)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= sub ? ~op_b : op_b;
      carry_q <= sub | cin;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (step) begin
      sum     <= sum_nxt;
      carry_q <= co_slice;
      idx_q   <= idx_q + IDX_W'(1);
      if (last) cout <= co_slice;
    end
  end

`ifdef SEQ_ADDER_FLAGS_EN
  logic ovf_q, zero_q;

  // Flags are taken from the completed sum on the final slice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (step && last) begin
      ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_nxt[WIDTH-1] != a_q[WIDTH-1]);
      zero_q <= ~|sum_nxt;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder: directed vectors, backpressure, reset abort, random ops.
module tb_seq_adder;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CHUNK  = 8;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
`ifdef SEQ_ADDER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif
  localparam longint MAXS = (longint'(1) << (WIDTH - 1)) - 1;
  localparam longint MINS = -(longint'(1) << (WIDTH - 1));

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] op_a, op_b;
  logic             cin, sub;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf, zero;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   acc_edge = 0;
  logic prev_ov = 1'b0;
  res_t exp_q[$];

  seq_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain wide integer arithmetic on the operands
  function automatic res_t model(input logic [WIDTH-1:0] a, b, input logic ci, sb);
    res_t   r;
    longint ua, ub, sa, sbv, ur, sr;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (sb) begin
      ur     = ua - ub;
      sr     = sa - sbv;
      r.cout = (ua >= ub);
    end else begin
      ur     = ua + ub + longint'(ci);
      sr     = sa + sbv + longint'(ci);
      r.cout = (ur >= (longint'(1) << WIDTH));
    end
    r.sum  = WIDTH'(ur);
    r.ovf  = FLAGS && ((sr > MAXS) || (sr < MINS));
    r.zero = FLAGS && (r.sum == '0);
    return r;
  endfunction

  // Compare process: every cycle out_valid is high, outputs must match the model
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          check("sum",  sum,  exp_q[0].sum);
          check("cout", cout, exp_q[0].cout);
          check("ovf",  ovf,  exp_q[0].ovf);
          check("zero", zero, exp_q[0].zero);
          check("in_ready_in_done", in_ready, 1'b0);
          if (!prev_ov) check("latency", 64'(cyc - acc_edge), 64'(NCHUNK));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(op_a, op_b, cin, sub));
        acc_edge = cyc + 1;
      end
      prev_ov = out_valid;
    end
  end

  task automatic do_op(input logic [WIDTH-1:0] a, b, input logic ci, sb,
                       input int hold, output res_t r);
    int n;
    @(posedge clk); #1;
    op_a = a; op_b = b; cin = ci; sub = sb; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("in_ready_wait", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    n = 0;
    while (!out_valid && n < 4 * NCHUNK + 4) begin @(posedge clk); #1; n++; end
    check("out_valid_wait", out_valid, 1'b1);
    r.sum = sum; r.cout = cout; r.ovf = ovf; r.zero = zero;
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        in_valid = 1'b1; op_a = WIDTH'(32'h1234); op_b = '0; cin = 1'b0; sub = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_in_ready",  in_ready,  1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_sum",  sum,  r.sum);
      check("bp_cout", cout, r.cout);
      check("bp_ovf",  ovf,  r.ovf);
      check("bp_zero", zero, r.zero);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_out_valid", out_valid, 1'b0);
    check("post_hs_in_ready",  in_ready,  1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t r;
    logic [WIDTH-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;

    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum",  sum,  '0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf",  ovf,  1'b0);
    check("rst_zero", zero, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // Carry wrap
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, r);
    check("t1_sum",  r.sum,  32'h0000_0000);
    check("t1_cout", r.cout, 1'b1);
    check("t1_zero", r.zero, FLAGS);
    check("t1_ovf",  r.ovf,  1'b0);

    // Subtract with cin ignored
    do_op(32'd5, 32'd7, 1'b1, 1'b1, 0, r);
    check("t2_sum",  r.sum,  32'hFFFF_FFFE);
    check("t2_cout", r.cout, 1'b0);
    check("t2_ovf",  r.ovf,  1'b0);
    check("t2_zero", r.zero, 1'b0);

    // Signed overflow, add and subtract
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, r);
    check("t3a_sum",  r.sum,  32'h8000_0000);
    check("t3a_cout", r.cout, 1'b0);
    check("t3a_ovf",  r.ovf,  FLAGS);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0, r);
    check("t3b_sum",  r.sum,  32'h7FFF_FFFF);
    check("t3b_cout", r.cout, 1'b1);
    check("t3b_ovf",  r.ovf,  FLAGS);

    // Equal subtract gives zero with no borrow; carry-in on add
    do_op(32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 0, r);
    check("t_eq_sum",  r.sum,  32'h0);
    check("t_eq_cout", r.cout, 1'b1);
    check("t_eq_zero", r.zero, FLAGS);
    do_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 0, r);
    check("t_cin_sum", r.sum, 32'h1);

    // Backpressure with an ignored in_valid pulse
    do_op(32'h0000_00FF, 32'h0000_0F01, 1'b0, 1'b0, 3, r);
    check("t4_sum", r.sum, 32'h0000_1000);

    // Reset during CALC aborts the operation
    @(posedge clk); #1;
    op_a = 32'h1111_1111; op_b = 32'h2222_2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t5_sum",       sum,       '0);
    check("t5_cout",      cout,      1'b0);
    check("t5_ovf",       ovf,       1'b0);
    check("t5_zero",      zero,      1'b0);
    check("t5_out_valid", out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t5_in_ready", in_ready, 1'b1);
    repeat (NCHUNK + 2) begin
      @(posedge clk); #1;
      check("t5_no_valid", out_valid, 1'b0);
    end
    do_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 0, r);
    check("t5_next_sum", r.sum, 32'h3333_3333);

    // Random operations checked by the compare process
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 10 == 0) rb = ~ra;
      if (i % 10 == 1) rb = ra;
      do_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), r);
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
